// File: rtl/vedic_pkg.sv
// ----------------------------------------------------------------------------
// Module : vedic_pkg
// Brief  : Shared FSM state encoding and carry-width helper for vedic_mult_seq.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package vedic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // A column holds at most WIDTH partial products plus the incoming carry.
  function automatic int carry_width(input int w);
    return $clog2(w) + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vedic_column_adder.sv
// ----------------------------------------------------------------------------
// Module : vedic_column_adder
// Brief  : Sums one Urdhva column: all op1[i]&op2[j] with i+j=col, plus carry.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module vedic_column_adder #(
  parameter int WIDTH = 16,
  parameter int CW    = 6
) (
  input  logic [$clog2(2*WIDTH)-1:0] col_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [CW-1:0]              carry_i,
  output logic [CW:0]                sum_o
);

  logic [2*WIDTH-1:0] w_sh;

  // b shifted by i puts b[col-i] at bit col, with zeros where j is out of range.
  always_comb begin
    w_sh  = '0;
    sum_o = (CW+1)'(carry_i);
    for (int i = 0; i < WIDTH; i++) begin
      w_sh  = {{WIDTH{1'b0}}, b_i} << i;
      sum_o = sum_o + (CW+1)'(a_i[i] & w_sh[col_i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vedic_mult_seq.sv
// ----------------------------------------------------------------------------
// Module : vedic_mult_seq
// Brief  : Sequential Urdhva-Tiryagbhyam multiplier, one product column per clock.
//          Optional macro VEDIC_MULT_SIGNED_EN adds op_signed (two's complement).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
`ifdef VEDIC_MULT_SIGNED_EN
  input  logic                 op_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(PW);
  localparam int CW = carry_width(WIDTH);
  localparam logic [IW-1:0] LAST_COL = IW'(PW - 2);

  state_t          state_q, state_d;
  logic [IW-1:0]   col_q, col_d;
  logic [CW-1:0]   carry_q, carry_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CW:0]     sum;

`ifdef VEDIC_MULT_SIGNED_EN
  logic sign_q, sign_d;
  assign a_mag = (op_signed && op1[WIDTH-1]) ? -op1 : op1;
  assign b_mag = (op_signed && op2[WIDTH-1]) ? -op2 : op2;
`else
  assign a_mag = op1;
  assign b_mag = op2;
`endif

  vedic_column_adder #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_col (
    .col_i   (col_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .carry_i (carry_q),
    .sum_o   (sum)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    carry_d = carry_q;
    prod_d  = prod_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef VEDIC_MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          col_d   = '0;
          carry_d = '0;
          prod_d  = '0;
`ifdef VEDIC_MULT_SIGNED_EN
          sign_d  = op_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d[col_q] = sum[0];
        carry_d       = sum[CW:1];
        if (col_q == LAST_COL) begin
          // Top product bit is the LSB of the final carry.
          prod_d[PW-1] = sum[1];
`ifdef VEDIC_MULT_SIGNED_EN
          if (sign_q) prod_d = -prod_d;
`endif
          state_d = DONE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      carry_q <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      carry_q <= carry_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef VEDIC_MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;

endmodule

`default_nettype wire

// File: tb/tb_vedic_mult_seq.sv
// ----------------------------------------------------------------------------
// Module : tb_vedic_mult_seq
// Brief  : Self-checking bench for vedic_mult_seq at WIDTH=8 and WIDTH=32.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vedic_mult_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv32, ir32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

`ifdef VEDIC_MULT_SIGNED_EN
  logic        sg8, sg32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vedic_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .op1       (a8),
    .op2       (b8),
`ifdef VEDIC_MULT_SIGNED_EN
    .op_signed (sg8),
`endif
    .out_valid (ov8),
    .out_ready (or8),
    .product   (p8),
    .busy      (busy8)
  );

  vedic_mult_seq #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .op1       (a32),
    .op2       (b32),
`ifdef VEDIC_MULT_SIGNED_EN
    .op_signed (sg32),
`endif
    .out_valid (ov32),
    .out_ready (or32),
    .product   (p32),
    .busy      (busy32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product of w-bit operands, result masked to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit sg, input int w);
    longint sa, sb;
    logic [63:0] r, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    r    = 64'(sa * sb);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return r & mask;
  endfunction

  // One WIDTH=8 transaction; hold>0 keeps out_ready low that many DONE cycles.
  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input bit sg,
                      input int hold, input logic [15:0] exp, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!ir8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_in_ready"}, 64'(ir8), 64'd1);
    iv8 = 1'b1;
    a8  = a;
    b8  = b;
`ifdef VEDIC_MULT_SIGNED_EN
    sg8 = sg;
`else
    if (sg) $display("note: signed request ignored in unsigned build");
`endif
    or8 = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(lat), 64'd15);
    chk({tag, "_product"}, 64'(p8), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      iv8 = h[0];
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_hold%0d_valid", tag, h), 64'(ov8), 64'd1);
      chk($sformatf("%s_hold%0d_prod", tag, h), 64'(p8), 64'(exp));
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(ir8), 64'd1);
    chk({tag, "_idle_valid"}, 64'(ov8), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    bit          rsg;
    int          lat, guard, seen;
    bit          done;

    rst  = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; or8  = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; or32 = 1'b0;
`ifdef VEDIC_MULT_SIGNED_EN
    sg8  = 1'b0; sg32 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(ir8), 64'd1);
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_product", 64'(p8), 64'd0);
    chk("rst_product32", p32, 64'd0);

    mul8(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, "ff_ff");
    mul8(8'h00, 8'hA5, 1'b0, 0, 16'h0000, "zero");
    mul8(8'h01, 8'hA5, 1'b0, 0, 16'h00A5, "one");
    mul8(8'h0D, 8'h0B, 1'b0, 10, 16'h008F, "backpress");

    // Abort in the middle of CALC: reset lands on the 5th CALC edge.
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_in_ready", 64'(ir8), 64'd1);
    chk("abort_product", 64'(p8), 64'd0);
    chk("abort_out_valid", 64'(ov8), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov8) seen = 1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    mul8(8'h03, 8'h05, 1'b0, 0, 16'h000F, "after_abort");

`ifdef VEDIC_MULT_SIGNED_EN
    mul8(8'hFD, 8'h05, 1'b1, 0, 16'hFFF1, "s_neg");
    mul8(8'h80, 8'h80, 1'b1, 0, 16'h4000, "s_min");
    mul8(8'hFD, 8'h05, 1'b0, 0, 16'h04F1, "u_fd");
`endif

    for (int v = 0; v < 20; v++) begin
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(0, 255));
`ifdef VEDIC_MULT_SIGNED_EN
      rsg = 1'($urandom);
`else
      rsg = 1'b0;
`endif
      rexp = ref_mul(ra, rb, rsg, 8);
      mul8(ra[7:0], rb[7:0], rsg, v % 3, rexp[15:0], $sformatf("r8_%0d", v));
    end

    for (int v = 0; v < 1000; v++) begin
      ra = $urandom;
      rb = $urandom;
`ifdef VEDIC_MULT_SIGNED_EN
      rsg = 1'($urandom);
`else
      rsg = 1'b0;
`endif
      rexp = ref_mul(ra, rb, rsg, 32);
      lat  = 0;
      @(negedge clk);
      while (!ir32 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      if (!ir32) chk($sformatf("w32_%0d_in_ready", v), 64'(ir32), 64'd1);
      iv32 = 1'b1;
      a32  = ra;
      b32  = rb;
`ifdef VEDIC_MULT_SIGNED_EN
      sg32 = rsg;
`endif
      @(posedge clk);
      @(negedge clk);
      iv32 = 1'b0;
      a32  = $urandom;
      b32  = $urandom;
      lat  = 0;
      while (!ov32 && lat < 200) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      chk($sformatf("w32_%0d_latency", v), 64'(lat), 64'd63);
      chk($sformatf("w32_%0d_product", v), p32, rexp);
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 100) begin
        or32 = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        done = or32;
        @(negedge clk);
        guard++;
      end
      or32 = 1'b0;
      chk($sformatf("w32_%0d_released", v), 64'(ov32), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
